// File: rtl/xgriscv_lsu_pkg.sv
// Shared constants for the xgriscv load/store unit.
//   DM_* : data-memory access type codes, identical to the decoder's DMType encoding.
//   lsu_state_e : LSU controller state encoding (IDLE / BUS / RESP).
package xgriscv_lsu_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    // Codes above DM_BYTE_U have no defined access width.
    function automatic logic dm_is_illegal(input logic [2:0] dm_type);
        return (dm_type > DM_BYTE_U);
    endfunction

endpackage

// File: rtl/xgriscv_lsu_align.sv
// Combinational lane logic for the LSU.
//   dm_type, offset (addr[1:0]) : access type and byte offset inside the word
//   wdata      : right-justified store data
//   mem_rdata  : raw word read from the bus
//   be         : byte enables, bit i = lane i
//   wdata_lane : store data replicated across the lanes
//   load_data  : shifted, sign/zero-extended load result
//   err        : misaligned address or illegal access type
module lsu_align
    import xgriscv_lsu_pkg::*;
(
    input  logic [2:0]  dm_type,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        err
);

    logic [31:0] shifted_s;

    // Byte enables, lane replication and error detection from type and offset.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'd0;
        err        = 1'b0;
        case (dm_type)
            DM_WORD: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                err        = (offset != 2'b00);
            end
            DM_HALF, DM_HALF_U: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                err        = offset[0];
            end
            DM_BYTE, DM_BYTE_U: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                err        = 1'b0;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = 32'd0;
                err        = dm_is_illegal(dm_type);
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend to 32 bits.
    always_comb begin
        shifted_s = mem_rdata >> {offset, 3'b000};
        load_data = 32'd0;
        case (dm_type)
            DM_WORD:   load_data = shifted_s;
            DM_HALF:   load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            DM_HALF_U: load_data = {16'd0, shifted_s[15:0]};
            DM_BYTE:   load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            DM_BYTE_U: load_data = {24'd0, shifted_s[7:0]};
            default:   load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/xgriscv_lsu.sv
// Multi-cycle load/store unit between execute and data memory.
//   clk, reset          : core clock, async active-high reset
//   req_*  / mem_write, dm_type, addr, wdata : operation request from the pipeline
//   resp_* : completion with extended load data and error flag
//   mem_*  : word-wide byte-enabled bus with req/ack handshake
// Misaligned or illegal requests complete with resp_err and never touch the bus.
module xgriscv_lsu
    import xgriscv_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_write,
    input  logic [2:0]  dm_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_r;
    lsu_state_e  state_next_s;
    logic        op_we_r;
    logic [2:0]  op_type_r;
    logic [1:0]  op_off_r;
    logic [2:0]  align_type_s;
    logic [1:0]  align_off_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_lane_s;
    logic [31:0] load_data_s;
    logic        err_s;

    // Align logic sees the live request while idle, the captured one afterwards.
    always_comb begin
        if (state_r == LSU_IDLE) begin
            align_type_s = dm_type;
            align_off_s  = addr[1:0];
        end else begin
            align_type_s = op_type_r;
            align_off_s  = op_off_r;
        end
    end

    lsu_align u_align (
        .dm_type    (align_type_s),
        .offset     (align_off_s),
        .wdata      (wdata),
        .mem_rdata  (mem_rdata),
        .be         (be_s),
        .wdata_lane (wdata_lane_s),
        .load_data  (load_data_s),
        .err        (err_s)
    );

    assign req_ready = (state_r == LSU_IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LSU_IDLE: begin
                if (req_valid) begin
                    state_next_s = err_s ? LSU_RESP : LSU_BUS;
                end else begin
                    state_next_s = LSU_IDLE;
                end
            end
            LSU_BUS: begin
                if (mem_ack) begin
                    state_next_s = LSU_RESP;
                end else begin
                    state_next_s = LSU_BUS;
                end
            end
            LSU_RESP: begin
                if (resp_ready) begin
                    state_next_s = LSU_IDLE;
                end else begin
                    state_next_s = LSU_RESP;
                end
            end
            default: state_next_s = LSU_IDLE;
        endcase
    end

    // Captured request and registered bus/response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_we_r    <= 1'b0;
            op_type_r  <= 3'b000;
            op_off_r   <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            case (state_r)
                LSU_IDLE: begin
                    if (req_valid) begin
                        op_we_r   <= mem_write;
                        op_type_r <= dm_type;
                        op_off_r  <= addr[1:0];
                        if (err_s) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= mem_write;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_s;
                            mem_wdata <= wdata_lane_s;
                        end
                    end
                end
                LSU_BUS: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= op_we_r ? 32'd0 : load_data_s;
                    end
                end
                LSU_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                    end
                end
                default: begin
                    mem_req    <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Self-checking bench for xgriscv_lsu: directed cases plus randomized
// operations compared against a byte-lane reference model.
module tb_xgriscv_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_write;
    logic [2:0]  dm_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    xgriscv_lsu dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_write  (mem_write),
        .dm_type    (dm_type),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] t);
        case (t)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            default:    return 1;
        endcase
    endfunction

    function automatic logic m_err(input logic [2:0] t, input logic [31:0] a);
        if (t > 3'd4) return 1'b1;
        return ((a % acc_size(t)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
        logic [3:0] b = 4'b0000;
        int off = int'(a % 4);
        int s = acc_size(t);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + s) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
        logic [31:0] w = 32'd0;
        int s = acc_size(t);
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = d[8*(i % s) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        logic [31:0] mask;
        int s = acc_size(t);
        if (s == 4) return v;
        mask = (s == 2) ? 32'h0000FFFF : 32'h000000FF;
        v = v & mask;
        if ((t == 3'd1 || t == 3'd3) && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- one complete operation ----------------
    task automatic run_op(input logic we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd,
                          input int stall, input int hold);
        logic        e = m_err(t, a);
        logic [31:0] exp_rd = (e || we) ? 32'd0 : m_load(t, a, rd);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; mem_write = we; dm_type = t; addr = a; wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        wdata = $urandom;
        addr = $urandom;
        dm_type = 3'($urandom_range(0, 7));
        if (e) begin
            chk("err_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("err_resp_err", {31'd0, resp_err}, 32'd1);
            chk("err_resp_rdata", resp_rdata, 32'd0);
            chk("err_no_mem_req", {31'd0, mem_req}, 32'd0);
            mem_ack = 1'b1;  // stray ack in RESP must be ignored
        end else begin
            for (int i = 0; i <= stall; i++) begin
                chk("bus_mem_req", {31'd0, mem_req}, 32'd1);
                chk("bus_mem_we", {31'd0, mem_we}, {31'd0, we});
                chk("bus_mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("bus_mem_be", {28'd0, mem_be}, {28'd0, m_be(t, a)});
                if (we) chk("bus_mem_wdata", mem_wdata, m_wdata(t, d));
                chk("bus_no_resp", {31'd0, resp_valid}, 32'd0);
                chk("bus_req_ready", {31'd0, req_ready}, 32'd0);
                resp_ready = 1'($urandom_range(0, 1));  // ignored outside RESP
                mem_rdata = $urandom;
                if (i == stall) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
                @(negedge clk);
                mem_ack = 1'b0;
            end
            chk("resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("resp_err", {31'd0, resp_err}, 32'd0);
            chk("resp_rdata", resp_rdata, exp_rd);
            chk("mem_req_dropped", {31'd0, mem_req}, 32'd0);
            mem_ack = 1'b1;  // stray ack in RESP must be ignored
        end
        resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_resp_rdata", resp_rdata, exp_rd);
            chk("hold_resp_err", {31'd0, resp_err}, {31'd0, e});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_no_mem_req", {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("consumed_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("consumed_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; mem_write = 1'b0; dm_type = 3'd0;
        addr = 32'd0; wdata = 32'd0; resp_ready = 1'b0; mem_ack = 1'b0;
        mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(1'b1, 3'd3, 32'h0000_1003, 32'hAABBCCDD, 32'h0, 0, 0);     // sb
        run_op(1'b0, 3'd3, 32'h0000_2002, 32'h0, 32'h12F45678, 0, 0);     // lb
        run_op(1'b0, 3'd4, 32'h0000_2002, 32'h0, 32'h12F45678, 1, 1);     // lbu
        run_op(1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 0);    // lh
        run_op(1'b0, 3'd0, 32'h0000_3006, 32'h0, 32'h0, 0, 1);            // lw misaligned
        run_op(1'b0, 3'd6, 32'h0000_3000, 32'h0, 32'h0, 0, 0);            // illegal type
        run_op(1'b1, 3'd0, 32'h0000_4000, 32'h1234_5678, 32'h0, 5, 3);    // sw, stall + hold

        // Reset while the bus request is outstanding
        req_valid = 1'b1; mem_write = 1'b0; dm_type = 3'd0; addr = 32'h0000_5000;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("late_ack_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        chk("late_ack_no_resp2", {31'd0, resp_valid}, 32'd0);

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            logic [2:0] t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                        : 3'($urandom_range(0, 4));
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(acc_size(t)) - 32'd1);
            run_op(1'($urandom_range(0, 1)), t, a, $urandom, $urandom,
                   $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
